// File: rtl/seg_decode.sv
// seg_decode: seven-segment loopback checker.
// Samples the eight active-low segment buses (HEX0..HEX7). It waits until
// they have held the same value for STABLE_CYCLES consecutive samples, then
// decodes one digit per cycle into a 32-bit value. The result is offered on a
// valid/ready handshake. An unknown segment pattern stops the scan and is
// reported through err/err_digit/err_pattern instead.
//
// Build option: define SEG_BLANK_EN to accept an all-dark digit (1111111)
// as nibble 0, for leading-blank displays. Without it, that pattern is illegal.
//
// Handshake: valid rises once all eight digits have decoded. While valid is
// high, value is frozen and ready is sampled on every rising edge. The edge
// that sees valid && ready completes the single transfer, and valid falls
// after it. ready is ignored while valid is low.

module seg_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [0:6]  HEX0,
  input  logic [0:6]  HEX1,
  input  logic [0:6]  HEX2,
  input  logic [0:6]  HEX3,
  input  logic [0:6]  HEX4,
  input  logic [0:6]  HEX5,
  input  logic [0:6]  HEX6,
  input  logic [0:6]  HEX7,
  output logic [31:0] value,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_digit,
  output logic [0:6]  err_pattern,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_SCAN = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Stability counter value on the last matching edge before the scan starts.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  state_t          state_q;
  state_t          state_d;

  // All 56 bus bits, digit n in element n, segment a in bit 6 of each element.
  logic [7:0][6:0] live;
  logic [7:0][6:0] snap_q;
  logic [7:0]      cnt_q;
  logic [2:0]      idx_q;

  // Digit selected for decoding this cycle and its decode result.
  logic [0:6]      cur_pat;
  logic            dec_legal;
  logic [3:0]      dec_nib;
  logic [4:0]      bit_base;

  // Control strobes from the FSM to the datapath.
  logic            snap_ld;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            idx_clr;
  logic            dig_wr;
  logic            err_set;
  logic            err_clr;
  logic            valid_set;
  logic            valid_clr;

  // Map one abcdefg pattern to {legal, nibble}. Active-low: 0 = segment lit.
  function automatic logic [4:0] seg_to_nib(input logic [0:6] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0001100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
`ifdef SEG_BLANK_EN
      7'b1111111: r = {1'b1, 4'h0};
`else
      7'b1111111: r = 5'b0_0000;
`endif
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Gather the live buses in the same layout as the snapshot.
  always_comb begin
    live = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  end

  // Decode the snapshot digit addressed by idx_q.
  always_comb begin
    cur_pat   = snap_q[idx_q];
    dec_legal = seg_to_nib(cur_pat)[4];
    dec_nib   = seg_to_nib(cur_pat)[3:0];
    bit_base  = {idx_q, 2'b00};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d   = state_q;
    snap_ld   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    idx_clr   = 1'b0;
    dig_wr    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    valid_set = 1'b0;
    valid_clr = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_WAIT;
          snap_ld = 1'b1;
          cnt_clr = 1'b1;
          err_clr = 1'b1;
        end
      end
      S_WAIT: begin
        if (live == snap_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_SCAN;
            idx_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          // Any change restarts the stability count from the new sample.
          snap_ld = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_SCAN: begin
        if (dec_legal) begin
          dig_wr = 1'b1;
          if (idx_q == 3'd7) begin
            state_d   = S_DONE;
            valid_set = 1'b1;
          end
        end else begin
          err_set = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        // valid is always high here, so ready alone completes the transfer.
        if (ready) begin
          valid_clr = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Snapshot, stability counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      cnt_q  <= 8'd0;
      idx_q  <= 3'd0;
    end else begin
      if (snap_ld) begin
        snap_q <= live;
      end
      if (cnt_clr) begin
        cnt_q <= 8'd0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (idx_clr) begin
        idx_q <= 3'd0;
      end else if (dig_wr) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // Result register: one nibble per legal decode, untouched otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 32'd0;
    end else if (dig_wr) begin
      value[bit_base +: 4] <= dec_nib;
    end
  end

  // valid flag for the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (valid_set) begin
      valid <= 1'b1;
    end else if (valid_clr) begin
      valid <= 1'b0;
    end
  end

  // Error report: captured on the first illegal digit, held until a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err         <= 1'b0;
      err_digit   <= 3'd0;
      err_pattern <= 7'd0;
    end else if (err_clr) begin
      err         <= 1'b0;
      err_digit   <= 3'd0;
      err_pattern <= 7'd0;
    end else if (err_set) begin
      err         <= 1'b1;
      err_digit   <= idx_q;
      err_pattern <= cur_pat;
    end
  end

  // Status outputs derived from the registered state.
  always_comb begin
    busy      = (state_q == S_WAIT) || (state_q == S_SCAN);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_seg_decode.sv
// tb_seg_decode: randomized scoreboard bench for seg_decode.
// The reference model encodes chosen hex values onto the buses. It predicts
// each scan outcome by looking every digit up in the segment table, and the
// monitor compares that prediction against whatever the DUT presents.

module tb_seg_decode;

  localparam int STABLE = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [0:6]  hex [8];
  logic [31:0] value;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        err;
  logic [2:0]  err_digit;
  logic [0:6]  err_pattern;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected entries: {is_err, value[31:0], err_digit[2:0], err_pattern[6:0]}.
  logic [42:0] exp_q[$];
  logic [31:0] model_val = 32'd0;

  seg_decode #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .HEX0(hex[0]), .HEX1(hex[1]), .HEX2(hex[2]), .HEX3(hex[3]),
    .HEX4(hex[4]), .HEX5(hex[5]), .HEX6(hex[6]), .HEX7(hex[7]),
    .value(value), .valid(valid), .ready(ready), .busy(busy),
    .err(err), .err_digit(err_digit), .err_pattern(err_pattern),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Segment table, abcdefg with a in bit 6, active-low.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  function automatic logic [55:0] enc(input logic [31:0] v);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = seg_of(v[4*i +: 4]);
    return r;
  endfunction

  // Reverse lookup: returns {legal, nibble}.
  function automatic logic [4:0] lookup(input logic [6:0] p);
    for (int n = 0; n < 16; n++) begin
      if (seg_of(4'(n)) == p) return {1'b1, 4'(n)};
    end
`ifdef SEG_BLANK_EN
    if (p == 7'b1111111) return {1'b1, 4'h0};
`endif
    return 5'b0_0000;
  endfunction

  task automatic set_bus(input logic [55:0] b);
    for (int i = 0; i < 8; i++) hex[i] = b[7*i +: 7];
  endtask

  // Predict the outcome of scanning the buses b; updates the value model.
  task automatic model_expect(input logic [55:0] b, output logic [42:0] e, output int bad);
    logic [31:0] v;
    logic [4:0]  r;
    v   = model_val;
    bad = -1;
    e   = '0;
    for (int i = 0; i < 8; i++) begin
      if (bad < 0) begin
        r = lookup(b[7*i +: 7]);
        if (r[4]) v[4*i +: 4] = r[3:0];
        else begin
          bad = i;
          e   = {1'b1, v, 3'(i), b[7*i +: 7]};
        end
      end
    end
    if (bad < 0) e = {1'b0, v, 3'd0, 7'd0};
    model_val = v;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic pv = 1'b0;
  logic pe = 1'b0;

  always @(negedge clk) begin
    logic [42:0] e;
    if (!rst_n) begin
      pv <= 1'b0;
      pe <= 1'b0;
    end else begin
      if ((valid && !pv) || (err && !pe)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(value), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", 64'({err, value, err_digit, err_pattern}), 64'(e));
        end
      end
      pv <= valid;
      pe <= err;
    end
  end

  // ---------------- driver ----------------
  // ini shown at start; switched to fin after edge chg (chg<0: fin throughout).
  // hold: cycles ready stays low once valid is up (0: ready high from start).
  task automatic run_capture(input logic [55:0] ini, input logic [55:0] fin,
                             input int chg, input int hold, input bit disturb);
    logic [42:0] e;
    int bad;
    int lat;
    int n;
    int bcnt;
    model_expect(fin, e, bad);
    exp_q.push_back(e);
    lat = (bad < 0) ? STABLE + 8 : STABLE + 1 + bad;
    if (chg >= 0 && ini != fin) lat += chg + 1;
    @(negedge clk);
    set_bus((chg >= 0) ? ini : fin);
    ready = (hold == 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n    = 0;
    bcnt = busy ? 1 : 0;
    if (chg == 0) set_bus(fin);
    while (!(valid || err) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (busy) bcnt++;
      if (chg > 0 && n == chg) set_bus(fin);
    end
    check("latency", 64'(n), 64'(lat));
    check("busy_cycles", 64'(bcnt), 64'(lat));
    if (bad >= 0) begin
      check("err_busy_low", 64'(busy), 64'd0);
      check("err_no_valid", 64'(valid), 64'd0);
    end else if (valid) begin
      if (hold > 0) begin
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          start = 1'b0;
          if (disturb && c == hold / 2) begin
            set_bus(enc($urandom));
            start = 1'b1;
          end
        end
        @(negedge clk);
        start = 1'b0;
        check("hold_valid", 64'(valid), 64'd1);
        check("hold_value", 64'(value), 64'(model_val));
        ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("valid_drop", 64'(valid), 64'd0);
      @(negedge clk);
      ready = 1'b0;
      check("idle_not_busy", 64'(busy), 64'd0);
      check("single_xfer", 64'(valid), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [55:0] b;
    logic [6:0]  p;
    int          bi;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    set_bus(enc(32'd0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_value", 64'(value), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_digit", 64'(err_digit), 64'd0);
    check("rst_err_pattern", 64'(err_pattern), 64'd0);
    rst_n = 1'b1;

    // Steady display, ready high throughout.
    run_capture(enc(32'h1234ABCD), enc(32'h1234ABCD), -1, 0, 1'b0);

    // HEX3 changes F -> 1 during the stability wait.
    run_capture(enc(32'h0000F000), enc(32'h00001000), 1, 0, 1'b0);

    // Illegal pattern on HEX5.
    b = enc(32'hFFFFFFFF);
    b[35 +: 7] = 7'b1111110;
    run_capture(b, b, -1, 0, 1'b0);

    // Long ready stall in DONE with input changes and a start pulse.
    run_capture(enc(32'hCAFE0123), enc(32'hCAFE0123), -1, 20, 1'b1);

    // Reset in the middle of a scan (idx = 4).
    @(negedge clk);
    set_bus(enc(32'h13572468));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (STABLE + 4) @(posedge clk);
    #1;
    check("partial_scan", 64'(value), 64'({model_val[31:16], 16'h2468}));
    rst_n = 1'b0;
    #1;
    check("midrst_value", 64'(value), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'({err, err_digit, err_pattern}), 64'd0);
    model_val = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_capture(enc(32'h89ABCDEF), enc(32'h89ABCDEF), -1, 3, 1'b0);

    // All segments dark.
    b = {8{7'b1111111}};
    run_capture(b, b, -1, 0, 1'b0);

    // Randomized captures.
    for (int t = 0; t < 25; t++) begin
      b = enc($urandom);
      if ($urandom_range(0, 3) == 0) begin
        bi = $urandom_range(0, 7);
        p  = 7'($urandom_range(0, 127));
        while (lookup(p)[4]) p = 7'($urandom_range(0, 127));
        b[7*bi +: 7] = p;
      end
      bi = $urandom_range(0, 4);
      run_capture(enc($urandom), b, int'($urandom_range(0, 3)) - 1, bi,
                  (bi >= 2) && ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
